// File: rtl/img_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | img_pkg : image geometry, step-select encodings and scan FSM states      |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package img_pkg;

   localparam int IMG_W   = 320;
   localparam int IMG_H   = 240;
   localparam int COORD_W = 10;
   localparam int ADDR_W  = 17;

   typedef enum logic [1:0] {
      STEP_SEL_1   = 2'd0,
      STEP_SEL_2   = 2'd1,
      STEP_SEL_4   = 2'd2,
      STEP_SEL_RSV = 2'd3
   } step_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Reserved code behaves as no decimation.
   function automatic logic [2:0] decode_step(input logic [1:0] sel);
      logic [2:0] step;
      case (sel)
         STEP_SEL_2: step = 3'd2;
         STEP_SEL_4: step = 3'd4;
         default:    step = 3'd1;
      endcase
      return step;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_addr_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_addr_gen_if : scan control and pixel-coordinate output bundle      |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
interface pixel_addr_gen_if #(
   parameter int COORD_W = img_pkg::COORD_W,
   parameter int ADDR_W  = img_pkg::ADDR_W
);
   logic               start;
   logic [1:0]         step_sel;
   logic               en;
   logic               busy;
   logic               valid;
   logic               last;
   logic               done;
   logic [COORD_W-1:0] img_x;
   logic [COORD_W-1:0] img_y;
   logic [ADDR_W-1:0]  address;

   modport master (
      input  start, step_sel, en,
      output busy, valid, last, done, img_x, img_y, address
   );

   modport slave (
      output start, step_sel, en,
      input  busy, valid, last, done, img_x, img_y, address
   );
endinterface
`default_nettype wire

// File: rtl/pixel_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixel_addr_gen : row-major raster address generator with 1/2/4 decimation|
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module pixel_addr_gen #(
   parameter int IMG_W   = img_pkg::IMG_W,
   parameter int IMG_H   = img_pkg::IMG_H,
   parameter int COORD_W = img_pkg::COORD_W,
   parameter int ADDR_W  = img_pkg::ADDR_W
) (
   input wire               clk,
   input wire               rst_n,
   pixel_addr_gen_if.master bus
);
   import img_pkg::state_e;
   import img_pkg::IDLE;
   import img_pkg::RUN;
   import img_pkg::DONE;
   import img_pkg::decode_step;

   localparam logic [COORD_W:0]  c_img_w_ext = (COORD_W+1)'(IMG_W);
   localparam logic [COORD_W:0]  c_img_h_ext = (COORD_W+1)'(IMG_H);
   localparam logic [ADDR_W-1:0] c_img_w_adr = ADDR_W'(IMG_W);

   state_e             r_state, w_state_nxt;
   logic [2:0]         r_step, w_step_nxt;
   logic [COORD_W-1:0] r_x, w_x_nxt;
   logic [COORD_W-1:0] r_y, w_y_nxt;
   logic [ADDR_W-1:0]  r_row_base, w_row_base_nxt;
   logic [ADDR_W-1:0]  r_addr, w_addr_nxt;

   logic [COORD_W:0]   w_x_sum;
   logic [COORD_W:0]   w_y_sum;
   logic               w_col_ok;
   logic               w_row_ok;
   logic [ADDR_W-1:0]  w_row_inc;

   // One extra bit keeps the edge-of-image sum from wrapping.
   assign w_x_sum  = (COORD_W+1)'(r_x) + (COORD_W+1)'(r_step);
   assign w_y_sum  = (COORD_W+1)'(r_y) + (COORD_W+1)'(r_step);
   assign w_col_ok = (w_x_sum < c_img_w_ext);
   assign w_row_ok = (w_y_sum < c_img_h_ext);

   always_comb begin
      w_row_inc = c_img_w_adr;
      case (r_step)
         3'd2:    w_row_inc = c_img_w_adr << 1;
         3'd4:    w_row_inc = c_img_w_adr << 2;
         default: w_row_inc = c_img_w_adr;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_step_nxt     = r_step;
      w_x_nxt        = r_x;
      w_y_nxt        = r_y;
      w_row_base_nxt = r_row_base;
      w_addr_nxt     = r_addr;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_step_nxt     = decode_step(bus.step_sel);
               w_x_nxt        = '0;
               w_y_nxt        = '0;
               w_row_base_nxt = '0;
               w_addr_nxt     = '0;
               w_state_nxt    = RUN;
            end
         end
         RUN: begin
            if (bus.en) begin
               if (w_col_ok) begin
                  w_x_nxt    = w_x_sum[COORD_W-1:0];
                  w_addr_nxt = r_addr + ADDR_W'(r_step);
               end else if (w_row_ok) begin
                  w_x_nxt        = '0;
                  w_y_nxt        = w_y_sum[COORD_W-1:0];
                  w_row_base_nxt = r_row_base + w_row_inc;
                  w_addr_nxt     = r_row_base + w_row_inc;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_step     <= 3'd1;
         r_x        <= '0;
         r_y        <= '0;
         r_row_base <= '0;
         r_addr     <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_step     <= w_step_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_row_base <= w_row_base_nxt;
         r_addr     <= w_addr_nxt;
      end
   end

   // Flags decode flopped state only, so no input reaches an output combinationally.
   assign bus.valid   = (r_state == RUN);
   assign bus.busy    = (r_state == RUN);
   assign bus.done    = (r_state == DONE);
   assign bus.last    = (r_state == RUN) && !w_col_ok && !w_row_ok;
   assign bus.img_x   = r_x;
   assign bus.img_y   = r_y;
   assign bus.address = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_pixel_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixel_addr_gen : scan-sequence bench for a 4x3 and a 320x240 instance |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_pixel_addr_gen;
   localparam int c_sw = 4;
   localparam int c_sh = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       r_big;
   logic       r_start;
   logic       r_en;
   logic [1:0] r_sel;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   pixel_addr_gen_if bus_s ();
   pixel_addr_gen_if bus_d ();

   pixel_addr_gen #(.IMG_W(c_sw), .IMG_H(c_sh)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));
   pixel_addr_gen dut_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

   assign bus_s.start    = r_start & ~r_big;
   assign bus_d.start    = r_start & r_big;
   assign bus_s.step_sel = r_sel;
   assign bus_d.step_sel = r_sel;
   assign bus_s.en       = r_en;
   assign bus_d.en       = r_en;

   logic        w_valid, w_busy, w_last, w_done;
   logic [9:0]  w_x, w_y;
   logic [16:0] w_addr;
   assign w_valid = r_big ? bus_d.valid   : bus_s.valid;
   assign w_busy  = r_big ? bus_d.busy    : bus_s.busy;
   assign w_last  = r_big ? bus_d.last    : bus_s.last;
   assign w_done  = r_big ? bus_d.done    : bus_s.done;
   assign w_x     = r_big ? bus_d.img_x   : bus_s.img_x;
   assign w_y     = r_big ? bus_d.img_y   : bus_s.img_y;
   assign w_addr  = r_big ? bus_d.address : bus_s.address;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(w_valid), 32'd0);
      chk({tag, "_busy"},  32'(w_busy),  32'd0);
      chk({tag, "_last"},  32'(w_last),  32'd0);
      chk({tag, "_done"},  32'(w_done),  32'd0);
      chk({tag, "_x"},     32'(w_x),     32'd0);
      chk({tag, "_y"},     32'(w_y),     32'd0);
      chk({tag, "_addr"},  32'(w_addr),  32'd0);
   endtask

   // Reference: pixel list built directly from the raster/decimation rules.
   task automatic scan(input bit big, input logic [1:0] sel, input int en_pct,
                       input int stall_idx, input bit noise, input int abort_idx);
      int s, w, h, n, idx, stall_cnt, budget;
      int qx[$];
      int qy[$];
      bit en_now;
      s = (sel == 2'd1) ? 2 : (sel == 2'd2) ? 4 : 1;
      w = big ? 320 : c_sw;
      h = big ? 240 : c_sh;
      for (int y = 0; y < h; y += s)
         for (int x = 0; x < w; x += s) begin
            qx.push_back(x);
            qy.push_back(y);
         end
      n = qx.size();
      r_big   = big;
      r_sel   = sel;
      r_en    = 1'b1;
      r_start = 1'b1;
      @(posedge clk); #1;
      r_start   = 1'b0;
      idx       = 0;
      stall_cnt = 0;
      budget    = 20 * n + 50;
      while (idx < n && budget > 0) begin
         if (idx == abort_idx) begin
            r_start = 1'b0;
            #2 rst_n = 1'b0;
            #1 chk_all_zero("async_rst");
            for (int k = 0; k < 2; k++) begin
               @(posedge clk); #1;
               chk("rst_hold_done", 32'(w_done), 32'd0);
               chk("rst_hold_valid", 32'(w_valid), 32'd0);
            end
            #3 rst_n = 1'b1;
            @(posedge clk); #1;
            chk("post_rst_idle_valid", 32'(w_valid), 32'd0);
            chk("post_rst_done", 32'(w_done), 32'd0);
            return;
         end
         chk("run_valid", 32'(w_valid), 32'd1);
         chk("run_busy",  32'(w_busy),  32'd1);
         chk("run_done",  32'(w_done),  32'd0);
         chk("img_x",     32'(w_x),     32'(qx[idx]));
         chk("img_y",     32'(w_y),     32'(qy[idx]));
         chk("address",   32'(w_addr),  32'(qy[idx] * w + qx[idx]));
         chk("last",      32'(w_last),  32'(idx == n - 1));
         if (idx == stall_idx && stall_cnt < 3) begin
            en_now = 1'b0;
            stall_cnt++;
         end else begin
            en_now = ($urandom_range(99) < en_pct);
         end
         r_en = en_now;
         if (noise) begin
            r_start = ($urandom_range(3) == 0);
            r_sel   = 2'($urandom);
         end
         @(posedge clk); #1;
         budget--;
         if (en_now) idx++;
      end
      r_start = 1'b0;
      if (budget == 0) begin
         checks++;
         errors++;
         $error("FAIL scan_budget observed=%0d expected=%0d", idx, n);
      end
      chk("done_pulse", 32'(w_done),  32'd1);
      chk("done_valid", 32'(w_valid), 32'd0);
      chk("done_busy",  32'(w_busy),  32'd0);
      chk("done_last",  32'(w_last),  32'd0);
      r_start = 1'b1;
      r_sel   = 2'($urandom);
      @(posedge clk); #1;
      r_start = 1'b0;
      chk("idle_done",  32'(w_done),  32'd0);
      chk("idle_valid", 32'(w_valid), 32'd0);
      chk("idle_busy",  32'(w_busy),  32'd0);
      @(posedge clk); #1;
      chk("start_at_done_dropped", 32'(w_valid), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      r_big   = 1'b0;
      r_start = 1'b0;
      r_en    = 1'b0;
      r_sel   = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      chk("reset_big_valid", 32'(bus_d.valid), 32'd0);
      chk("reset_big_addr",  32'(bus_d.address), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      scan(1'b0, 2'd0, 100, -1, 1'b0, -1);
      scan(1'b0, 2'd1, 100, -1, 1'b0, -1);
      scan(1'b0, 2'd2, 100, -1, 1'b0, -1);
      scan(1'b0, 2'd3, 100, -1, 1'b0, -1);
      scan(1'b0, 2'd0, 100,  5, 1'b0, -1);
      scan(1'b0, 2'd0, 100, -1, 1'b1, -1);
      scan(1'b0, 2'd0, 100, -1, 1'b0,  6);
      scan(1'b0, 2'd0, 100, -1, 1'b0, -1);
      for (int i = 0; i < 8; i++)
         scan(1'b0, 2'($urandom_range(3)), int'($urandom_range(100, 30)), -1, 1'b1, -1);
      scan(1'b1, 2'd0, 100, -1, 1'b0, -1);
      scan(1'b1, 2'd2, 100, -1, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pixel_addr_gen.md
# pixel_addr_gen

Raster-scan address generator: the stage directly upstream of the pipeline register bank. On a start request it walks the source image in row-major order and emits one pixel coordinate pair and linear memory address per cycle, to the image memory read port and the alignment register stage. An optional decimation step (1, 2 or 4) supports zoom-out passes. Addresses are computed incrementally, with no multiplier.

## Interface
- IMG_W, 320, source image width in pixels
- IMG_H, 240, source image height in pixels
- COORD_W, 10, coordinate width
- ADDR_W, 17, memory address width; must hold IMG_W*IMG_H-1

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a frame scan
- step_sel  in  2  decimation code: 0→1, 1→2, 2→4, 3→1 (reserved); sampled only when a start is accepted
- en  in  1  downstream advance; the current output is consumed on a cycle where valid && en
- busy  out  1  scan in progress, from acceptance through the last pixel
- valid  out  1  img_x/img_y/address hold a valid pixel
- last  out  1  high with the final pixel of the frame
- done  out  1  one-cycle pulse after the final pixel is consumed
- img_x  out  COORD_W  pixel column
- img_y  out  COORD_W  pixel row
- address  out  ADDR_W  img_y*IMG_W + img_x

## Operation
- States: IDLE, RUN, DONE.
- IDLE: valid=0, busy=0.
  - start=1 latches the decoded step into an internal register (values 1, 2 or 4), clears x, y, row_base and address, and moves to RUN.
- RUN: valid=1, busy=1. Outputs hold while en=0. On valid && en:
  - If x+step < IMG_W: x += step; address += step.
  - Else if y+step < IMG_H: x=0; y += step; row_base += step*IMG_W; address = new row_base.
  - Else (final pixel): go to DONE.
- Compare x+step and y+step at COORD_W+1 bits so the sum cannot overflow at the image edge. step*IMG_W is a shift-and-add of a constant, computed at ADDR_W bits.
- last = 1 in RUN when both the column and the row tests fail, i.e. on the final pixel.
- DONE: done=1 and valid=0 for exactly one cycle, then IDLE unconditionally.
- start is ignored in RUN and DONE. It is accepted only in IDLE, so a start coincident with the done pulse is dropped.
- step_sel changes during a scan have no effect.
- Output pixel count: ceil(IMG_W/step) * ceil(IMG_H/step). Last pixel x = largest multiple of step below IMG_W; same rule for y.

## Timing
- Reset (async assert, any state): state=IDLE; busy, valid, last and done = 0; img_x, img_y and address = 0; step register = 1. A reset in mid-scan abandons the frame with no done pulse.
- start accepted at edge N → valid=1 and (0,0,0) visible after edge N. Latency is 1 cycle.
- Throughput: 1 pixel per cycle while en=1.
- Final pixel consumed at edge M → done=1 during cycle M+1 → IDLE at M+2. The earliest next start is accepted at edge M+2.
- All outputs are registered; none are combinational from inputs.
- The downstream register stage adds 1 cycle; memory read data aligns with the coordinates after that stage.

## Structure
- Shared package img_pkg holds: IMG_W, IMG_H, COORD_W, ADDR_W; the step_sel encodings and the decode function; the state enum (IDLE/RUN/DONE). The register bank and scaler stages import the same constants.
- Single module; no sub-module is warranted. The counters, row_base accumulator and FSM together are small.

## Test plan
All scenarios run with IMG_W=4, IMG_H=3 unless noted.
- Full scan, step_sel=0, en=1: 12 valid cycles with addresses 0..11.
  - (x,y) runs (0,0)..(3,2); last high only at (3,2), address 11.
  - done pulses 1 cycle later; busy falls with done.
- Decimation, step_sel=1: 4 pixels, (0,0)/0, (2,0)/2, (0,2)/8, (2,2)/10; last at address 10.
  - step_sel=2: 1 pixel (0,0)/0 with last=1.
- Stall: hold en=0 for 3 cycles at (1,1)/5. Outputs stay frozen and valid stays 1; the scan resumes to (2,1)/6 with no skipped or duplicated addresses.
- Start handling: a start pulse during RUN and a start pulse coincident with done are both ignored. A second scan then runs cleanly from (0,0). A step_sel change mid-scan has no effect.
- Reset mid-scan: assert rst_n=0 asynchronously at (2,1), between clock edges. All outputs go to 0 immediately and no done pulse occurs. After release, start begins again at address 0.
- Default parameters (320x240), step_sel=0: final address 76799 at (319,239); count 76800.
  - step_sel=2: last at (316,236); count 80*60=4800.
